// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-pair and RAM-side signals of the single-port memory arbiter
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] igrant_cnt;
    logic [31:0] dgrant_cnt;
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               igrant_cnt, dgrant_cnt
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               igrant_cnt, dgrant_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache, dcache first with icache starvation guard
// Define MEM_ARB_STATS_EN to count ACCESS completions per requester.
module mem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input logic CLK,
    input logic RST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
    localparam logic [1:0] ACCESS = 2'd2;
    state_t state, next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic starved, dreq, iacc, dacc;
    always_comb begin
        dreq       = bus.dREN | bus.dWEN;
        starved    = starve_cnt == CNT_W'(STARVE_MAX);
        iacc       = state == IGRANT && bus.iREN && bus.ramstate == ACCESS;
        dacc       = state == DGRANT && dreq && bus.ramstate == ACCESS;
        next_state = state == IDLE   ? (dreq && !starved ? DGRANT : bus.iREN ? IGRANT : IDLE) :
                     state == IGRANT ? (!bus.iREN || iacc ? IDLE : IGRANT) :
                     state == DGRANT ? (!dreq || dacc ? IDLE : DGRANT) : IDLE;
        // Enables follow the live request so a dropped request releases RAM in the same cycle
        bus.ramREN   = state == IGRANT ? bus.iREN : state == DGRANT && bus.dREN && !bus.dWEN;
        bus.ramWEN   = state == DGRANT && bus.dWEN;
        bus.ramaddr  = state == IGRANT ? bus.iaddr : state == DGRANT ? bus.daddr : '0;
        bus.ramstore = state == DGRANT ? bus.dstore : '0;
        bus.iwait    = !iacc;
        bus.iload    = iacc ? bus.ramload : '0;
        bus.dwait    = !dacc;
        bus.dload    = dacc ? bus.ramload : '0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= !bus.iREN || next_state == IGRANT ? '0 :
                          state != IGRANT && !starved ? starve_cnt + CNT_W'(1) : starve_cnt;
        end
    end
`ifdef MEM_ARB_STATS_EN
    logic [31:0] icnt, dcnt;
    always_ff @(posedge CLK) begin
        if (RST) begin
            icnt <= '0;
            dcnt <= '0;
        end else begin
            icnt <= icnt + {31'd0, iacc};
            dcnt <= dcnt + {31'd0, dacc};
        end
    end
    assign bus.igrant_cnt = icnt;
    assign bus.dgrant_cnt = dcnt;
`else
    assign bus.igrant_cnt = '0;
    assign bus.dgrant_cnt = '0;
`endif
endmodule
